uart_rx: RTL and testbench

// - 8N1 UART receiver; the receive-side counterpart of the uartFsmTx transmitter.
// - Synchronises the async rxd line and oversamples it 16x.
// - Validates the start bit at mid-bit and samples data LSB first.
// - Checks the stop bit and delivers each byte on a valid/ready output register.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_tick_gen.sv | 35 +++
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample tick positions and
// the baud divider calculation used by both the RX and TX sides.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam logic [3:0] OS_MID  = 4'd7;
   localparam logic [3:0] OS_LAST = 4'd15;

   // Truncated clocks-per-tick, never below 1 so the divider always advances.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int div;
      div = clk_freq / (baud * oversample);
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-clk pulse every DIV clocks, restartable so the
// receiver can lock its sampling phase to the start-bit edge.
module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: reset here is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised input, 16x oversampled mid-bit sampling,
// stop-bit check and a valid/ready output register with overrun detection.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rxd,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                 r_rxd_meta;
   logic                 r_rxd_s;
   logic                 r_rxd_q;
   uart_state_t          r_state;
   logic [3:0]           r_os_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shreg;
   logic                 r_stop_good;
   logic                 r_stop_bad;
   logic                 w_tick;
   logic                 w_start_edge;

   // NOTE: the synchroniser presets to the idle level so reset release never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
         r_rxd_q    <= 1'b1;
      end else begin
         r_rxd_meta <= i_rxd;
         r_rxd_s    <= r_rxd_meta;
         r_rxd_q    <= r_rxd_s;
      end
   end

   assign w_start_edge = (r_state == IDLE) && r_rxd_q && !r_rxd_s;

   uart_rx_tick_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start_edge),
      .o_tick (w_tick)
   );

   // NOTE: stop flags default low every clk so they can only ever be single-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_os_cnt    <= '0;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_stop_good <= 1'b0;
         r_stop_bad  <= 1'b0;
      end else begin
         r_stop_good <= 1'b0;
         r_stop_bad  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_edge) begin
                  r_state  <= START;
                  r_os_cnt <= '0;
               end
            end
            START: begin
               if (w_tick) begin
                  if (r_os_cnt == OS_MID) begin
                     if (!r_rxd_s) begin
                        r_state   <= DATA;
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_os_cnt <= r_os_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_os_cnt <= r_os_cnt + 1'b1;
                  if (r_os_cnt == OS_LAST) begin
                     r_shreg <= {r_rxd_s, r_shreg[DATA_BITS-1:1]};
                     if (r_bit_cnt == LAST_BIT) begin
                        r_state <= STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_os_cnt <= r_os_cnt + 1'b1;
                  if (r_os_cnt == OS_LAST) begin
                     r_stop_good <= r_rxd_s;
                     r_stop_bad  <= !r_rxd_s;
                     r_state     <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A good byte may replace a held one only if the consumer takes the old one this same clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_rx_data   <= '0;
         o_rx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= r_stop_bad;
         o_overrun   <= 1'b0;
         if (r_stop_good) begin
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_data  <= r_shreg;
               o_rx_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 64 clk/bit: directed frames drive rxd,
// a negedge monitor pops expected bytes on every valid/ready transfer.
module tb_uart_rx;

   localparam int BIT_CLK = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         n_valid_hi = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   logic       ferr_prev = 1'b0;
   logic       ovr_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ   (6_400_000),
      .BAUD       (100_000),
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rxd       (rxd),
      .o_rx_data   (rx_data),
      .o_rx_valid  (rx_valid),
      .i_rx_ready  (rx_ready),
      .o_frame_err (frame_err),
      .o_overrun   (overrun),
      .o_busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs change 1 time unit after posedge, so negedge sees a settled picture.
   always @(negedge clk) begin
      if (rst) begin
         ferr_prev = 1'b0;
         ovr_prev  = 1'b0;
      end else begin
         if (rx_valid) n_valid_hi++;
         if (rx_valid && rx_ready) begin
            check("sb_byte_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("sb_rx_data", rx_data, exp_q.pop_front());
         end
         if (frame_err) begin
            n_ferr++;
            check("frame_err_1clk", ferr_prev, 0);
         end
         if (overrun) begin
            n_ovr++;
            check("overrun_1clk", ovr_prev, 0);
         end
         ferr_prev = frame_err;
         ovr_prev  = overrun;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      idle(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(BIT_CLK);
      end
      rxd = stop_bit;
      idle(BIT_CLK);
      rxd = 1'b1;
      idle(BIT_CLK / 2);
   endtask

   initial begin
      int base_v, base_f, base_o;
      bit seen;

      idle(5);
      rst = 1'b0;
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      idle(20);

      // Clean 0xA5 with the consumer always ready.
      rx_ready = 1'b1;
      base_v = n_valid_hi; base_f = n_ferr; base_o = n_ovr;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(BIT_CLK);
      check("a5_valid_cycles", n_valid_hi - base_v, 1);
      check("a5_rx_data", rx_data, 8'hA5);
      check("a5_no_ferr", n_ferr - base_f, 0);
      check("a5_no_ovr", n_ovr - base_o, 0);

      // 20-clk low glitch must not start a frame.
      base_v = n_valid_hi; base_f = n_ferr; base_o = n_ovr;
      rxd = 1'b0;
      idle(10);
      check("glitch_busy_during", busy, 1);
      idle(10);
      rxd = 1'b1;
      idle(40);
      check("glitch_busy_after", busy, 0);
      idle(BIT_CLK * 2);
      check("glitch_no_valid", n_valid_hi - base_v, 0);
      check("glitch_no_pulses", (n_ferr - base_f) + (n_ovr - base_o), 0);

      // 0x3C with a bad stop bit, then a clean 0x55.
      base_v = n_valid_hi; base_f = n_ferr;
      send_frame(8'h3C, 1'b0);
      idle(BIT_CLK);
      check("ferr_count", n_ferr - base_f, 1);
      check("ferr_no_valid", n_valid_hi - base_v, 0);
      check("ferr_busy_idle", busy, 0);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      idle(BIT_CLK);
      check("after_ferr_rx_data", rx_data, 8'h55);

      // Held byte 0x11, then 0x22 overruns and is dropped.
      rx_ready = 1'b0;
      base_o = n_ovr;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("ovr_count", n_ovr - base_o, 1);
      check("ovr_rx_valid", rx_valid, 1);
      check("ovr_rx_data", rx_data, 8'h11);
      rx_ready = 1'b1;
      check("ovr_valid_before_ready", rx_valid, 1);
      step();
      check("ovr_valid_drop", rx_valid, 0);
      rx_ready = 1'b0;
      idle(BIT_CLK);

      // Consumer takes 0x11 in the same clk that 0x22 lands: no overrun.
      base_o = n_ovr;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
               if (busy) begin seen = 1'b1; break; end
               step();
            end
            check("handoff_busy_rise", seen, 1);
            seen = 1'b0;
            for (int i = 0; i < 1000; i++) begin
               step();
               if (!busy) begin seen = 1'b1; break; end
            end
            check("handoff_busy_fall", seen, 1);
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
         end
      join
      check("handoff_rx_valid", rx_valid, 1);
      check("handoff_rx_data", rx_data, 8'h22);
      check("handoff_no_ovr", n_ovr - base_o, 0);
      rx_ready = 1'b1;
      idle(3);
      check("handoff_drained", rx_valid, 0);

      // Reset in the middle of data bit 4, then a full 0xFF frame.
      rxd = 1'b0;
      idle(BIT_CLK * 5 + BIT_CLK / 2);
      check("mid_reset_busy_before", busy, 1);
      rst = 1'b1;
      rxd = 1'b1;
      step();
      check("mid_reset_rx_valid", rx_valid, 0);
      check("mid_reset_rx_data", rx_data, 8'h00);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_pulses", {frame_err, overrun}, 2'b00);
      rst = 1'b0;
      idle(BIT_CLK * 2);
      check("mid_reset_still_idle", busy, 0);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1);
      idle(BIT_CLK);
      check("ff_rx_data", rx_data, 8'hFF);
      check("ff_rx_valid_consumed", rx_valid, 0);

      check("sb_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
